// File: rtl/debug_regfile_dumper_if.sv
// Byte-stream handshake between the register-file dumper and the UART transmitter.
// The master drives the byte and its valid flag; the slave answers with ready.
interface debug_regfile_dumper_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/debug_regfile_dumper.sv
// Freezes the pipeline, walks the register file through its debug read port and
// streams a header byte followed by every 32-bit word MSB-first, then releases the pipeline.
module debug_regfile_dumper #(
  parameter int          NUM_REGS = 32,
  parameter int          READ_LAT = 1,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          dbg_on,
  output logic                          stop_debug,
  output logic [4:0]                    dbg_read_reg,
  input  logic [31:0]                   dbg_data,
  debug_regfile_dumper_if.master        tx,
  output logic                          busy,
  output logic                          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FREEZE = 3'd1;
  localparam logic [2:0] S_HDR    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FREEZE;
      S_FREEZE: begin
        idx_d   = '0;
        state_d = S_HDR;
      end
      S_HDR: if (tx.tx_ready) begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          shreg_d = dbg_data;
          bcnt_d  = '0;
          state_d = S_SEND;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_SEND: if (tx.tx_ready) begin
        shreg_d = {shreg_q[23:0], 8'h00};
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Read address follows the next index so the regfile read starts in the cycle of
  // the last accepted byte; the WAIT count then lands exactly on valid data.
  assign dbg_read_reg = idx_d;
  assign busy         = (state_q != S_IDLE);
  assign dbg_on       = busy;
  assign stop_debug   = busy;
  assign done         = (state_q == S_DONE);
  assign tx.tx_valid  = (state_q == S_HDR) || (state_q == S_SEND);
  assign tx.tx_data   = (state_q == S_HDR)  ? HEADER :
                        (state_q == S_SEND) ? shreg_q[31:24] : '0;

endmodule

// File: tb/tb_debug_regfile_dumper.sv
// Scoreboard bench: expected byte streams and done cycles are queued at start time and
// popped by per-instance monitors; a second instance runs with READ_LAT=2.
module tb_debug_regfile_dumper;
  localparam int         NR  = 32;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic dbg_on_a, stop_a, busy_a, done_a;
  logic dbg_on_b, stop_b, busy_b, done_b;
  logic [4:0]  rr_a, rr_b;
  logic [31:0] data_a, data_b, pipe_b;

  debug_regfile_dumper_if ifa ();
  debug_regfile_dumper_if ifb ();

  debug_regfile_dumper dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .dbg_on(dbg_on_a), .stop_debug(stop_a),
    .dbg_read_reg(rr_a), .dbg_data(data_a), .tx(ifa), .busy(busy_a), .done(done_a)
  );

  debug_regfile_dumper #(.READ_LAT(2)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .dbg_on(dbg_on_b), .stop_debug(stop_b),
    .dbg_read_reg(rr_b), .dbg_data(data_b), .tx(ifb), .busy(busy_b), .done(done_b)
  );

  logic [31:0] regs [NR];
  always @(posedge clk) data_a <= regs[rr_a];
  always @(posedge clk) begin
    pipe_b <= regs[rr_b];
    data_b <= pipe_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0, err_cnt = 0;
  logic [7:0] qa[$], qb[$];
  int qd_a[$], qd_b[$];
  int acc_a = 0, done_cnt_a = 0, done_cnt_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready driver: mode 0 = always ready except a planned stall, mode 1 = random
  int rdy_mode = 0, stall_at = -1, stall_n = 0, stall_used = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) ifa.tx_ready = ($urandom_range(3) != 0);
    else if (stall_used < stall_n && acc_a == stall_at && ifa.tx_valid) begin
      ifa.tx_ready = 1'b0;
      stall_used++;
    end else ifa.tx_ready = 1'b1;
  end

  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;
  always @(negedge clk) begin
    if (!rst_n) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        chk("hold_valid_a", 32'(ifa.tx_valid), 1);
        chk("hold_data_a", 32'(ifa.tx_data), 32'(hold_data));
      end
      hold_pend = 1'b0;
      if (ifa.tx_valid && qa.size() == 0) chk("unexpected_valid_a", 32'(ifa.tx_valid), 0);
      else if (ifa.tx_valid && ifa.tx_ready) begin
        chk("byte_a", 32'(ifa.tx_data), 32'(qa.pop_front()));
        acc_a++;
      end else if (ifa.tx_valid) begin
        hold_pend = 1'b1;
        hold_data = ifa.tx_data;
      end
      if (done_a) begin
        done_cnt_a++;
        if (qd_a.size() == 0) chk("unexpected_done_a", 32'(done_a), 0);
        else begin
          int e;
          e = qd_a.pop_front();
          if (e >= 0) chk("done_cycle_a", cyc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.tx_valid && qb.size() == 0) chk("unexpected_valid_b", 32'(ifb.tx_valid), 0);
      else if (ifb.tx_valid && ifb.tx_ready) chk("byte_b", 32'(ifb.tx_data), 32'(qb.pop_front()));
      if (done_b) begin
        done_cnt_b++;
        if (qd_b.size() == 0) chk("unexpected_done_b", 32'(done_b), 0);
        else chk("done_cycle_b", cyc, qd_b.pop_front());
      end
    end
  end

  task automatic push_stream_a();
    qa.push_back(HDR);
    for (int r = 0; r < NR; r++)
      for (int b = 3; b >= 0; b--) qa.push_back(8'(regs[r] >> (8 * b)));
  endtask

  task automatic push_stream_b();
    qb.push_back(HDR);
    for (int r = 0; r < NR; r++)
      for (int b = 3; b >= 0; b--) qb.push_back(8'(regs[r] >> (8 * b)));
  endtask

  task automatic pulse_start_a(output int c0);
    @(posedge clk); #1;
    start_a = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b(output int c0);
    @(posedge clk); #1;
    start_b = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done_a(input int target, input int limit);
    int n = 0;
    while (done_cnt_a < target && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached_a", done_cnt_a, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, base, d0, n;
    ifb.tx_ready = 1'b1;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;

    // reset held with start asserted
    start_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dbg_on", 32'(dbg_on_a), 0);
    chk("rst_stop", 32'(stop_a), 0);
    chk("rst_read_reg", 32'(rr_a), 0);
    chk("rst_tx_data", 32'(ifa.tx_data), 0);
    chk("rst_tx_valid", 32'(ifa.tx_valid), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    start_a = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_done_cnt", done_cnt_a, 0);

    // full dump, ready tied high
    pulse_start_a(c0);
    push_stream_a();
    qd_a.push_back(c0 + 163);
    chk("stop_cycle1", 32'(stop_a), 1);
    chk("dbg_on_cycle1", 32'(dbg_on_a), 1);
    chk("busy_cycle1", 32'(busy_a), 1);
    goto_cycle(c0 + 163);
    chk("stop_cycle163", 32'(stop_a), 1);
    chk("done_cycle163", 32'(done_a), 1);
    goto_cycle(c0 + 164);
    chk("stop_after_done", 32'(stop_a), 0);
    chk("busy_after_done", 32'(busy_a), 0);
    chk("dbg_on_after_done", 32'(dbg_on_a), 0);
    chk("bytes_left_full", qa.size(), 0);

    // 5-cycle stall on the second byte of reg 3
    stall_at = acc_a + 14;
    stall_n  = stall_used + 5;
    pulse_start_a(c0);
    push_stream_a();
    qd_a.push_back(c0 + 168);
    wait_done_a(done_cnt_a + 1, 400);
    chk("bytes_left_stall", qa.size(), 0);
    chk("stall_used", stall_used, stall_n);

    // random contents with random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      pulse_start_a(c0);
      push_stream_a();
      qd_a.push_back(-1);
      wait_done_a(done_cnt_a + 1, 2000);
      chk("bytes_left_rand", qa.size(), 0);
    end
    rdy_mode = 0;

    // READ_LAT=2 instance
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    pulse_start_b(c0);
    push_stream_b();
    qd_b.push_back(c0 + 195);
    goto_cycle(c0 + 200);
    chk("done_cnt_b", done_cnt_b, 1);
    chk("bytes_left_b", qb.size(), 0);

    // starts during a dump and on the done cycle are ignored
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    d0 = done_cnt_a;
    pulse_start_a(c0);
    push_stream_a();
    qd_a.push_back(c0 + 163);
    goto_cycle(c0 + 20);
    start_a = 1'b1;
    goto_cycle(c0 + 21);
    start_a = 1'b0;
    goto_cycle(c0 + 163);
    start_a = 1'b1;
    goto_cycle(c0 + 164);
    start_a = 1'b0;
    goto_cycle(c0 + 170);
    chk("single_done", done_cnt_a - d0, 1);
    chk("bytes_left_ignored", qa.size(), 0);
    chk("idle_after_ignored", 32'(busy_a), 0);

    // abort in SEND of reg 10, then a fresh dump
    base = acc_a;
    pulse_start_a(c0);
    push_stream_a();
    n = 0;
    while (acc_a < base + 42 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_point", acc_a - base, 42);
    rst_n = 1'b0;
    #1;
    chk("abort_stop", 32'(stop_a), 0);
    chk("abort_dbg_on", 32'(dbg_on_a), 0);
    chk("abort_tx_valid", 32'(ifa.tx_valid), 0);
    chk("abort_busy", 32'(busy_a), 0);
    qa.delete();
    qd_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start_a(c0);
    push_stream_a();
    qd_a.push_back(c0 + 163);
    wait_done_a(done_cnt_a + 1, 400);
    chk("bytes_left_restart", qa.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
